// File: rtl/psram_pkg.sv
// Shared command codes, phase boundaries and FSM encoding for the QSPI PSRAM responder.
package psram_pkg;

    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;

    localparam int CMD_NIBS      = 2;
    localparam int ADDR_LAST_NIB = 7;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/psram_mem_array.sv
// Single-port DEPTH x 8 byte RAM, synchronous write and 1-cycle synchronous read.
module psram_mem_array #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              re,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; contents are whatever was there before.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/psram_qspi_responder.sv
// Device side of EBh quad-read / 38h quad-write PSRAM transactions, backed by an on-chip byte array.
module psram_qspi_responder
    import psram_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DEPTH         = 2**ADDR_W,
    parameter int DUMMY_NIBBLES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic       douten,
    output logic       bad_cmd
);

    localparam logic [7:0] NIB_CMD_LAST   = 8'(CMD_NIBS - 1);
    localparam logic [7:0] NIB_ADDR_LAST  = 8'(ADDR_LAST_NIB);
    localparam logic [7:0] NIB_DUMMY_LAST = 8'(ADDR_LAST_NIB + DUMMY_NIBBLES);

    state_t            state, state_nx;
    logic              sck_q, ce_q;
    logic              rise, fall;
    logic [7:0]        nib;
    logic [3:0]        cmd_hi, wr_hi;
    logic [7:0]        cmd_byte;
    logic              cmd_ok, is_read;
    logic              half;
    logic              rd_req;
    logic              mem_we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        rd_data;

    assign rise     = sck & ~sck_q & ~ce_n;
    assign fall     = ~sck & sck_q & ~ce_n;
    assign cmd_byte = {cmd_hi, din};
    assign cmd_ok   = (cmd_byte == CMD_QREAD) || (cmd_byte == CMD_QWRITE);
    assign mem_we   = rise && (state == WDATA) && half;

    psram_mem_array #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .addr  (addr),
        .we    (mem_we),
        .re    (rd_req),
        .wdata ({wr_hi, din}),
        .rdata (rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: state_nx gets its default first so no path through the case can infer a latch.
    always_comb begin
        state_nx = state;
        if (ce_n) begin
            state_nx = IDLE;
        end else begin
            case (state)
                // ce_q low after reset means ce_n must be seen high before a new decode starts.
                IDLE:  if (ce_q) state_nx = CMD;
                CMD:   if (rise && nib == NIB_CMD_LAST) state_nx = cmd_ok ? ADDR : IGNORE;
                ADDR:  if (rise && nib == NIB_ADDR_LAST) state_nx = is_read ? DUMMY : WDATA;
                DUMMY: if (rise && nib == NIB_DUMMY_LAST) state_nx = RDATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q   <= 1'b0;
            ce_q    <= 1'b0;
            nib     <= '0;
            cmd_hi  <= '0;
            wr_hi   <= '0;
            is_read <= 1'b0;
            half    <= 1'b0;
            rd_req  <= 1'b0;
            addr    <= '0;
            dout    <= '0;
            douten  <= 1'b0;
            bad_cmd <= 1'b0;
        end else begin
            sck_q  <= sck;
            ce_q   <= ce_n;
            rd_req <= 1'b0;
            if (ce_n) begin
                nib    <= '0;
                half   <= 1'b0;
                douten <= 1'b0;
            end else begin
                if (rise) nib <= nib + 8'd1;
                if (rise && nib == 8'd0) cmd_hi <= din;
                if (rise && state == CMD && nib == NIB_CMD_LAST) begin
                    is_read <= (cmd_byte == CMD_QREAD);
                    if (!cmd_ok) bad_cmd <= 1'b1;
                end
                if (rise && state == ADDR) begin
                    addr <= {addr[ADDR_W-5:0], din};
                    if (nib == NIB_ADDR_LAST) begin
                        rd_req <= 1'b1;
                        half   <= 1'b0;
                    end
                end
                // Write: hold the high nibble, commit the byte on its second rise.
                if (rise && state == WDATA) begin
                    half <= ~half;
                    if (!half) begin
                        wr_hi <= din;
                    end else begin
                        addr   <= addr + ADDR_W'(1);
                        rd_req <= 1'b1;
                    end
                end
                // Read: the prefetched byte goes out high nibble then low nibble on successive falls.
                if (fall && state == RDATA) begin
                    half <= ~half;
                    if (!half) begin
                        dout   <= rd_data[7:4];
                        douten <= 1'b1;
                    end else begin
                        dout   <= rd_data[3:0];
                        addr   <= addr + ADDR_W'(1);
                        rd_req <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
